// File: rtl/mult_pkg.sv
// Shared types and elaboration helpers for the sequential multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic bit bpc_allowed(input int k);
    return (k == 1) || (k == 2) || (k == 4) || (k == 8);
  endfunction

  // A single-step configuration still needs a one-bit counter.
  function automatic int count_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pp_row_adder.sv
// Combinational acc + mcand * slice, built from K ripple rows of full adders.
module pp_row_adder #(
  parameter int WIDTH = 32,
  parameter int K     = 1
) (
  input  logic [WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [K-1:0]       slice,
  output logic [WIDTH+K-1:0] sum
);

  // Row j adds mcand gated by slice[j]; its LSB is final, the rest feeds row j+1.
  for (genvar j = 0; j < K; j++) begin : g_row
    logic [WIDTH-1:0] row_in;
    logic [WIDTH-1:0] row_s;
    logic             row_co;

    if (j == 0) begin : g_first
      assign row_in = acc;
    end else begin : g_next
      assign row_in = {g_row[j-1].row_co, g_row[j-1].row_s[WIDTH-1:1]};
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic cin;
      logic co;

      if (i == 0) begin : g_c0
        assign cin = 1'b0;
      end else begin : g_cn
        assign cin = g_bit[i-1].co;
      end

      sumador u_fa (
        .a    (row_in[i]),
        .b    (mcand[i] & slice[j]),
        .cin  (cin),
        .s    (row_s[i]),
        .cout (co)
      );
    end

    assign row_co = g_bit[WIDTH-1].co;

    if (j < K - 1) begin : g_low
      assign sum[j] = row_s[0];
    end
  end

  assign sum[WIDTH+K-1:K-1] = {g_row[K-1].row_co, g_row[K-1].row_s};

endmodule

// File: rtl/sumador.sv
// One-bit full adder, the building block of the partial-product rows.
module sumador (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/mult_secuencial_param.sv
// Sequential multiplier retiring BITS_PER_CYCLE multiplier bits per clock,
// with signed/unsigned mode and valid/ready handshakes on both sides.
module mult_secuencial_param
  import mult_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] resultado
);

  localparam int K  = BITS_PER_CYCLE;
  localparam int N  = WIDTH / K;
  localparam int CW = count_width(N);

  if (WIDTH < 2 || !bpc_allowed(BITS_PER_CYCLE) || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_param_check
    $error("mult_secuencial_param: illegal WIDTH/BITS_PER_CYCLE combination");
  end

  state_t             state, next_state;
  logic [WIDTH-1:0]   mcand;
  logic               neg;
  logic               zero_op;
  logic [2*WIDTH-1:0] p;
  logic [2*WIDTH-1:0] p_next;
  logic [CW-1:0]      count;
  logic [WIDTH+K-1:0] row_sum;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic               last_step;

  // Magnitudes; -2^(W-1) maps onto itself, which is correct read as unsigned.
  assign abs_a     = (signed_mode && A[WIDTH-1]) ? -A : A;
  assign abs_b     = (signed_mode && B[WIDTH-1]) ? -B : B;
  assign last_step = (count == CW'(N - 1));

  pp_row_adder #(
    .WIDTH (WIDTH),
    .K     (K)
  ) u_row (
    .acc   (p[2*WIDTH-1:WIDTH]),
    .mcand (mcand),
    .slice (p[K-1:0]),
    .sum   (row_sum)
  );

  if (K == WIDTH) begin : g_p_full
    assign p_next = row_sum;
  end else begin : g_p_shift
    assign p_next = {row_sum, p[WIDTH-1:K]};
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = ST_BUSY;
      end
      ST_BUSY: begin
        if (zero_op || last_step) next_state = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Operand capture, shift-add steps and the final sign correction.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      mcand     <= '0;
      neg       <= 1'b0;
      zero_op   <= 1'b0;
      p         <= '0;
      count     <= '0;
      resultado <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            mcand   <= abs_a;
            neg     <= signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
            zero_op <= (A == '0) || (B == '0);
            p       <= {{WIDTH{1'b0}}, abs_b};
            count   <= '0;
          end
        end
        ST_BUSY: begin
          if (zero_op) begin
            resultado <= '0;
          end else begin
            p     <= p_next;
            count <= count + CW'(1);
            if (last_step) resultado <= neg ? -p_next : p_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_secuencial_param.sv
// Directed bench: a W=8/K=1 and a W=32/K=4 instance driven from vector tables
// plus hand-written backpressure and mid-operation reset sequences.
module tb_mult_secuencial_param;

  logic        clk;
  logic        reset_L;

  logic        in_valid8, in_ready8, sm8, out_valid8, out_ready8;
  logic [7:0]  a8, b8;
  logic [15:0] res8;

  logic        in_valid32, in_ready32, sm32, out_valid32, out_ready32;
  logic [31:0] a32, b32;
  logic [63:0] res32;

  int compared;
  int mismatched;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sm;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t t8[10];
  vec_t t32[7];

  mult_secuencial_param #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8 (
    .clk(clk), .reset_L(reset_L), .in_valid(in_valid8), .in_ready(in_ready8),
    .A(a8), .B(b8), .signed_mode(sm8), .out_valid(out_valid8),
    .out_ready(out_ready8), .resultado(res8)
  );

  mult_secuencial_param #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut32 (
    .clk(clk), .reset_L(reset_L), .in_valid(in_valid32), .in_ready(in_ready32),
    .A(a32), .B(b32), .signed_mode(sm32), .out_valid(out_valid32),
    .out_ready(out_ready32), .resultado(res32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] getRes(input int sel);
    return (sel == 0) ? {48'b0, res8} : res32;
  endfunction

  function automatic logic getValid(input int sel);
    return (sel == 0) ? out_valid8 : out_valid32;
  endfunction

  function automatic logic getReady(input int sel);
    return (sel == 0) ? in_ready8 : in_ready32;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one operation and wait (bounded) until the result is presented.
  task automatic applyStimulus(input int sel, input logic [31:0] a, input logic [31:0] b,
                               input logic sm, output logic [63:0] res, output int lat);
    @(negedge clk);
    if (sel == 0) begin
      a8 = a[7:0]; b8 = b[7:0]; sm8 = sm; in_valid8 = 1'b1;
    end else begin
      a32 = a; b32 = b; sm32 = sm; in_valid32 = 1'b1;
    end
    @(posedge clk);
    #1;
    in_valid8  = 1'b0;
    in_valid32 = 1'b0;
    lat = 0;
    while (!getValid(sel) && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = getRes(sel);
  endtask

  task automatic releaseOutput(input int sel, input string name);
    @(negedge clk);
    in_valid8 = 1'b0;
    in_valid32 = 1'b0;
    if (sel == 0) out_ready8 = 1'b1;
    else          out_ready32 = 1'b1;
    @(posedge clk);
    #1;
    out_ready8  = 1'b0;
    out_ready32 = 1'b0;
    checkOutput({name, " idle in_ready"}, {63'b0, getReady(sel)}, 64'd1);
    checkOutput({name, " idle out_valid"}, {63'b0, getValid(sel)}, 64'd0);
  endtask

  initial begin
    logic [63:0] res;
    int          lat;

    compared   = 0;
    mismatched = 0;

    t8[0] = '{32'd200,  32'd150,  1'b0, 64'h7530, 8};
    t8[1] = '{32'h80,   32'h80,   1'b1, 64'h4000, 8};
    t8[2] = '{32'hFD,   32'h05,   1'b1, 64'hFFF1, 8};
    t8[3] = '{32'h7F,   32'h80,   1'b1, 64'hC080, 8};
    t8[4] = '{32'hFF,   32'hFF,   1'b0, 64'hFE01, 8};
    t8[5] = '{32'hFF,   32'hFF,   1'b1, 64'h0001, 8};
    t8[6] = '{32'h80,   32'h80,   1'b0, 64'h4000, 8};
    t8[7] = '{32'hFF,   32'h01,   1'b1, 64'hFFFF, 8};
    t8[8] = '{32'h00,   32'h05,   1'b1, 64'h0000, 1};
    t8[9] = '{32'h0C,   32'h00,   1'b0, 64'h0000, 1};

    t32[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 8};
    t32[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001, 8};
    t32[2] = '{32'h00000000, 32'h00001234, 1'b0, 64'h0000000000000000, 1};
    t32[3] = '{32'h12345678, 32'h00000010, 1'b0, 64'h0000000123456780, 8};
    t32[4] = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, 8};
    t32[5] = '{32'hFFFFFFFE, 32'h00000003, 1'b1, 64'hFFFFFFFFFFFFFFFA, 8};
    t32[6] = '{32'h80000000, 32'h80000000, 1'b0, 64'h4000000000000000, 8};

    reset_L = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; sm8 = 1'b0; out_ready8 = 1'b0;
    in_valid32 = 1'b0; a32 = '0; b32 = '0; sm32 = 1'b0; out_ready32 = 1'b0;
    #23;
    checkOutput("reset in_ready8", {63'b0, in_ready8}, 64'd1);
    checkOutput("reset out_valid8", {63'b0, out_valid8}, 64'd0);
    checkOutput("reset res8", {48'b0, res8}, 64'd0);
    checkOutput("reset in_ready32", {63'b0, in_ready32}, 64'd1);
    checkOutput("reset out_valid32", {63'b0, out_valid32}, 64'd0);
    checkOutput("reset res32", res32, 64'd0);
    @(negedge clk);
    reset_L = 1'b1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, t8[i].a, t8[i].b, t8[i].sm, res, lat);
      checkOutput($sformatf("v8[%0d] res", i), res, t8[i].exp);
      checkOutput($sformatf("v8[%0d] latency", i), 64'(lat), 64'(t8[i].lat));
      releaseOutput(0, $sformatf("v8[%0d]", i));
    end

    for (int i = 0; i < 7; i++) begin
      applyStimulus(1, t32[i].a, t32[i].b, t32[i].sm, res, lat);
      checkOutput($sformatf("v32[%0d] res", i), res, t32[i].exp);
      checkOutput($sformatf("v32[%0d] latency", i), 64'(lat), 64'(t32[i].lat));
      releaseOutput(1, $sformatf("v32[%0d]", i));
    end

    // Backpressure: result must hold while in_valid toggles in DONE.
    applyStimulus(0, 32'd200, 32'd150, 1'b0, res, lat);
    checkOutput("bp res", res, 64'h7530);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      a8 = 8'd1; b8 = 8'd1;
      in_valid8 = (c % 2 == 0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("bp[%0d] res", c), {48'b0, res8}, 64'h7530);
      checkOutput($sformatf("bp[%0d] out_valid", c), {63'b0, out_valid8}, 64'd1);
      checkOutput($sformatf("bp[%0d] in_ready", c), {63'b0, in_ready8}, 64'd0);
    end
    releaseOutput(0, "bp");

    // Reset asserted in the middle of a BUSY phase.
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd150; sm8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("busy in_ready", {63'b0, in_ready8}, 64'd0);
    #1;
    reset_L = 1'b0;
    #1;
    checkOutput("midrst in_ready", {63'b0, in_ready8}, 64'd1);
    checkOutput("midrst out_valid", {63'b0, out_valid8}, 64'd0);
    checkOutput("midrst res", {48'b0, res8}, 64'd0);
    @(negedge clk);
    reset_L = 1'b1;
    applyStimulus(0, 32'd7, 32'd6, 1'b0, res, lat);
    checkOutput("after rst res", res, 64'd42);
    checkOutput("after rst latency", 64'(lat), 64'd8);
    releaseOutput(0, "after rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
